// File: rtl/merge_reduce_sequencer.sv
// merge_reduce_sequencer: folds the masked input heads of one merge node
// through a shared, externally pipelined float adder, in ascending port order.

`ifndef DW
`define DW 34
`endif
`ifndef BODY
`define BODY 2'b10
`endif

module merge_reduce_sequencer #(
    parameter logic [4:0] input_mask = 5'b0,
    parameter logic [4:0] output_sel = 5'b0,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [`DW-1:0]   data_i [5],
    input  logic [4:0]       valid_i,
    output logic [4:0]       ready_o,
    output logic [`DW-1:0]   data_o [5],
    output logic [4:0]       valid_o,
    input  logic [4:0]       ready_i,
    output logic             add_req_o,
    output logic [`DW-3:0]   add_a_o,
    output logic [`DW-3:0]   add_b_o,
    input  logic [`DW-3:0]   add_res_i,
    input  logic             add_res_valid_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] set_cnt_o,
    output logic             err_o
);

    localparam int FW = `DW - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t        state;
    logic [FW-1:0] acc;
    logic [2:0]    cur;

    logic [2:0]    first_idx;
    logic [2:0]    second_idx;
    logic          has_second;
    logic [2:0]    next_idx;
    logic          has_next;
    logic [FW-1:0] first_data;
    logic [FW-1:0] cur_data;
    logic          set_present;
    logic          out_fire;
    logic          unused_flit_bits;

    // Flit-type bits of the incoming heads carry no meaning here.
    assign unused_flit_bits = ^{data_i[0][`DW-1:FW], data_i[1][`DW-1:FW],
                                data_i[2][`DW-1:FW], data_i[3][`DW-1:FW],
                                data_i[4][`DW-1:FW]};

    // A set starts only once every participating head is present.
    assign set_present = (input_mask != 5'b0) &&
                         ((valid_i & input_mask) == input_mask);

    // Any selected downstream consumer accepting completes the output.
    assign out_fire = |(ready_i & output_sel);

    // Masked port order: first port, the one after it, and the one after cur.
    always_comb begin
        first_idx  = 3'd0;
        second_idx = 3'd0;
        has_second = 1'b0;
        next_idx   = 3'd0;
        has_next   = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (input_mask[i]) begin
                first_idx = 3'(i);
            end
        end
        for (int i = 4; i >= 0; i--) begin
            if (input_mask[i] && (i > int'(first_idx))) begin
                second_idx = 3'(i);
                has_second = 1'b1;
            end
            if (input_mask[i] && (i > int'(cur))) begin
                next_idx = 3'(i);
                has_next = 1'b1;
            end
        end
    end

    // Operand muxes for the first pop and for the port currently being issued.
    always_comb begin
        first_data = '0;
        cur_data   = '0;
        for (int i = 0; i < 5; i++) begin
            if (first_idx == 3'(i)) begin
                first_data = data_i[i][FW-1:0];
            end
            if (cur == 3'(i)) begin
                cur_data = data_i[i][FW-1:0];
            end
        end
    end

    // Pop strobes: first port on set detection, current port at issue.
    always_comb begin
        ready_o = '0;
        unique case (state)
            IDLE: begin
                if (set_present) begin
                    ready_o = 5'b1 << first_idx;
                end
            end
            ISSUE: begin
                ready_o = 5'b1 << cur;
            end
            default: begin
                ready_o = '0;
            end
        endcase
    end

    assign add_req_o = (state == ISSUE);
    assign add_a_o   = add_req_o ? acc : '0;
    assign add_b_o   = add_req_o ? cur_data : '0;
    assign valid_o   = (state == OUT) ? output_sel : 5'b0;
    assign busy_o    = (state != IDLE);

    // Result flit on the selected ports, an empty body flit elsewhere.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            data_o[i] = {`BODY, (valid_o[i] ? acc : {FW{1'b0}})};
        end
    end

    // Sequencer: capture first operand, then one outstanding add at a time.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            acc       <= '0;
            cur       <= '0;
            set_cnt_o <= '0;
            err_o     <= 1'b0;
        end else begin
            if (add_res_valid_i && (state != WAIT)) begin
                err_o <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (set_present) begin
                        acc <= first_data;
                        if (has_second) begin
                            cur   <= second_idx;
                            state <= ISSUE;
                        end else begin
                            state <= OUT;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (add_res_valid_i) begin
                        acc <= add_res_i;
                        if (has_next) begin
                            cur   <= next_idx;
                            state <= ISSUE;
                        end else begin
                            state <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        set_cnt_o <= set_cnt_o + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
